// File: rtl/sumador_serie_pkg.sv
// ----------------------------------------------------------------------------
// sumador_serie_pkg
// Shared definitions for the bit-serial adder slice:
//   - SUMADOR_N_DEFAULT : default operand/result width
//   - estado_t          : control FSM state encoding (IDLE=0, SUMA=1, FIN=2)
//   - mayoria()         : 3-input majority, i.e. the carry of a full adder
// No ports (package).
// ----------------------------------------------------------------------------
package sumador_serie_pkg;

    localparam int SUMADOR_N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUMA = 2'd1,
        FIN  = 2'd2
    } estado_t;

    // Carry-out of a full adder: true when at least two inputs are set.
    function automatic logic mayoria(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sumador_serie_celda_suma.sv
// ----------------------------------------------------------------------------
// celda_suma
// Purely combinational 1-bit full-adder cell used by sumador_serie.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit  (a ^ b ^ cin)
//   cout  : carry out (majority of a, b, cin)
// ----------------------------------------------------------------------------
module celda_suma
    import sumador_serie_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Classic full adder; the carry comes from the shared majority helper so
    // that the definition lives in one place.
    assign s    = a ^ b ^ cin;
    assign cout = mayoria(a, b, cin);

endmodule

// File: rtl/sumador_serie.sv
// ----------------------------------------------------------------------------
// sumador_serie
// Bit-serial N-bit adder. Operands are captured on an accepted start and then
// added LSB-first, one bit per clock, through a single full-adder cell whose
// carry is fed back through a register. The result appears on S/Co together
// with a one-cycle done pulse; S/Co hold until the next completion and never
// show partial sums.
//
// Parameters:
//   N      : operand/result width (N >= 2)
// Ports:
//   clk    : clock, rising edge active
//   rst    : asynchronous active-high reset
//   start  : operation request, only sampled in IDLE
//   A, B   : operands, captured on accepted start
//   Ci     : initial carry in, captured on accepted start
//   S, Co  : sum and carry out of the last completed operation
//   busy   : high while the serial addition is running
//   done   : one-cycle pulse in the cycle S/Co have just updated
//   V      : signed overflow of the last completed operation
//            (only present when SUMADOR_SERIE_OVF_EN is defined)
// Configuration macro: SUMADOR_SERIE_OVF_EN
// ----------------------------------------------------------------------------
module sumador_serie
    import sumador_serie_pkg::*;
#(
    parameter int N = SUMADOR_N_DEFAULT
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         busy,
    output logic         done
`ifdef SUMADOR_SERIE_OVF_EN
   ,output logic         V
`endif
);

    localparam int CW = $clog2(N);

    estado_t         state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    ra;
    logic [N-1:0]    rb;
    logic [N-2:0]    rs;
    logic            c;
    logic            s_bit;
    logic            c_next;
    logic [N-1:0]    rs_next;
    logic            last_bit;

    // The single full-adder cell always works on the current LSBs of the
    // operand shift registers and the registered carry.
    celda_suma u_celda (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (c),
        .s    (s_bit),
        .cout (c_next)
    );

    // The partial sum only needs N-1 stored bits: the newest bit enters at the
    // top and the oldest falls off the bottom. On the final bit the freshly
    // computed sum bit completes the full N-bit result.
    assign rs_next  = {s_bit, rs};
    assign last_bit = (cnt == CW'(N - 1));

    // busy is a plain decode of the registered state.
    assign busy = (state == SUMA);

    // Control FSM plus the operand, partial-sum, carry and counter registers.
    // Results are written to S/Co (and V) only on the last bit, so the
    // outputs keep the previous result for the whole of SUMA. While the
    // overflow feature is on, the registered carry c during the last bit is
    // exactly the carry into the MSB, so V is c XOR the final carry out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            S     <= '0;
            Co    <= 1'b0;
            done  <= 1'b0;
`ifdef SUMADOR_SERIE_OVF_EN
            V     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= A;
                        rb    <= B;
                        c     <= Ci;
                        cnt   <= '0;
                        state <= SUMA;
                    end
                end
                SUMA: begin
                    c   <= c_next;
                    rs  <= rs_next[N-1:1];
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        S     <= rs_next;
                        Co    <= c_next;
                        done  <= 1'b1;
`ifdef SUMADOR_SERIE_OVF_EN
                        V     <= c ^ c_next;
`endif
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_serie.sv
// ----------------------------------------------------------------------------
// tb_sumador_serie
// Directed self-checking bench for sumador_serie (N = 8). Each scenario task
// drives its stimulus and compares DUT outputs against hand-computed values.
// Inputs are driven and outputs sampled on the falling clock edge.
// Configuration macro: SUMADOR_SERIE_OVF_EN (enables the V checks).
// ----------------------------------------------------------------------------
module tb_sumador_serie;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] A;
    logic [7:0] B;
    logic       Ci;
    logic [7:0] S;
    logic       Co;
    logic       busy;
    logic       done;
`ifdef SUMADOR_SERIE_OVF_EN
    logic       V;
`endif

    int checks = 0;
    int fails  = 0;

    sumador_serie #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .S     (S),
        .Co    (Co),
        .busy  (busy),
        .done  (done)
`ifdef SUMADOR_SERIE_OVF_EN
       ,.V     (V)
`endif
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something in the bench itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pulses start for one cycle with the given operands, then scrambles the
    // operand inputs and waits (bounded) until done is seen. Returns the number
    // of busy cycles observed and whether S moved before done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          output int busy_cycles, output logic timed_out,
                          output logic partial_seen);
        logic [7:0] s_before;
        s_before     = S;
        busy_cycles  = 0;
        timed_out    = 1'b1;
        partial_seen = 1'b0;
        @(negedge clk);
        A = a; B = b; Ci = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b; Ci = ~ci;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            if (busy === 1'b1) busy_cycles++;
            if (S !== s_before) partial_seen = 1'b1;
            @(negedge clk);
        end
    endtask

    // Async reset with no clock edge in between assertion and sampling.
    task automatic test_reset();
        rst = 1'b0; start = 1'b0; A = '0; B = '0; Ci = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (S !== 8'h00)  begin fails++; $display("[TB] FAIL reset_S: got %h expected 00", S); end
        checks++; if (Co !== 1'b0)  begin fails++; $display("[TB] FAIL reset_Co: got %b expected 0", Co); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        int   bc;
        logic to, ps;
        run_op(8'h0F, 8'h01, 1'b0, bc, to, ps);
        checks++; if (to !== 1'b0)   begin fails++; $display("[TB] FAIL basic_timeout: got %b expected 0", to); end
        checks++; if (bc !== 8)      begin fails++; $display("[TB] FAIL basic_busy_cycles: got %0d expected 8", bc); end
        checks++; if (ps !== 1'b0)   begin fails++; $display("[TB] FAIL basic_partial_sum: got %b expected 0", ps); end
        checks++; if (S !== 8'h10)   begin fails++; $display("[TB] FAIL basic_S: got %h expected 10", S); end
        checks++; if (Co !== 1'b0)   begin fails++; $display("[TB] FAIL basic_Co: got %b expected 0", Co); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_in_fin: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
        checks++; if (S !== 8'h10)   begin fails++; $display("[TB] FAIL basic_S_hold: got %h expected 10", S); end
    endtask

    task automatic test_carry_chain();
        int   bc;
        logic to, ps;
        run_op(8'hFF, 8'h01, 1'b0, bc, to, ps);
        checks++; if (to !== 1'b0)  begin fails++; $display("[TB] FAIL wrap_timeout: got %b expected 0", to); end
        checks++; if (S !== 8'h00)  begin fails++; $display("[TB] FAIL wrap_S: got %h expected 00", S); end
        checks++; if (Co !== 1'b1)  begin fails++; $display("[TB] FAIL wrap_Co: got %b expected 1", Co); end
        run_op(8'hFF, 8'hFF, 1'b1, bc, to, ps);
        checks++; if (to !== 1'b0)  begin fails++; $display("[TB] FAIL allones_timeout: got %b expected 0", to); end
        checks++; if (S !== 8'hFF)  begin fails++; $display("[TB] FAIL allones_S: got %h expected FF", S); end
        checks++; if (Co !== 1'b1)  begin fails++; $display("[TB] FAIL allones_Co: got %b expected 1", Co); end
    endtask

    // start held high through the whole first operation with new operands
    // on the inputs: they must only be taken once the FSM is back in IDLE.
    task automatic test_start_while_busy();
        logic seen;
        @(negedge clk);
        A = 8'h12; B = 8'h34; Ci = 1'b0; start = 1'b1;
        @(negedge clk);
        A = 8'hAA; B = 8'h55;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL hold_first_timeout: got %b expected 1", seen); end
        checks++; if (S !== 8'h46)   begin fails++; $display("[TB] FAIL hold_first_S: got %h expected 46", S); end
        checks++; if (Co !== 1'b0)   begin fails++; $display("[TB] FAIL hold_first_Co: got %b expected 0", Co); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL hold_idle_busy: got %b expected 0", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL hold_second_busy: got %b expected 1", busy); end
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (seen !== 1'b1) begin fails++; $display("[TB] FAIL hold_second_timeout: got %b expected 1", seen); end
        checks++; if (S !== 8'hFF)   begin fails++; $display("[TB] FAIL hold_second_S: got %h expected FF", S); end
        checks++; if (Co !== 1'b0)   begin fails++; $display("[TB] FAIL hold_second_Co: got %b expected 0", Co); end
    endtask

    // Reset in the middle of SUMA, away from any clock edge; the previous
    // result (FF) must be wiped immediately.
    task automatic test_reset_mid_op();
        int   bc;
        logic to, ps;
        @(negedge clk);
        A = 8'h80; B = 8'h80; Ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        checks++; if (S !== 8'h00)   begin fails++; $display("[TB] FAIL midrst_S: got %h expected 00", S); end
        checks++; if (Co !== 1'b0)   begin fails++; $display("[TB] FAIL midrst_Co: got %b expected 0", Co); end
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h01, 8'h02, 1'b0, bc, to, ps);
        checks++; if (to !== 1'b0)   begin fails++; $display("[TB] FAIL after_rst_timeout: got %b expected 0", to); end
        checks++; if (S !== 8'h03)   begin fails++; $display("[TB] FAIL after_rst_S: got %h expected 03", S); end
        checks++; if (Co !== 1'b0)   begin fails++; $display("[TB] FAIL after_rst_Co: got %b expected 0", Co); end
    endtask

`ifdef SUMADOR_SERIE_OVF_EN
    task automatic test_overflow();
        int   bc;
        logic to, ps;
        run_op(8'h7F, 8'h01, 1'b0, bc, to, ps);
        checks++; if (S !== 8'h80) begin fails++; $display("[TB] FAIL ovf_pos_S: got %h expected 80", S); end
        checks++; if (Co !== 1'b0) begin fails++; $display("[TB] FAIL ovf_pos_Co: got %b expected 0", Co); end
        checks++; if (V !== 1'b1)  begin fails++; $display("[TB] FAIL ovf_pos_V: got %b expected 1", V); end
        run_op(8'h80, 8'h80, 1'b0, bc, to, ps);
        checks++; if (S !== 8'h00) begin fails++; $display("[TB] FAIL ovf_neg_S: got %h expected 00", S); end
        checks++; if (Co !== 1'b1) begin fails++; $display("[TB] FAIL ovf_neg_Co: got %b expected 1", Co); end
        checks++; if (V !== 1'b1)  begin fails++; $display("[TB] FAIL ovf_neg_V: got %b expected 1", V); end
        run_op(8'h05, 8'h03, 1'b0, bc, to, ps);
        checks++; if (S !== 8'h08) begin fails++; $display("[TB] FAIL ovf_none_S: got %h expected 08", S); end
        checks++; if (V !== 1'b0)  begin fails++; $display("[TB] FAIL ovf_none_V: got %b expected 0", V); end
    endtask
`endif

    // Scenario sequence followed by the summary line.
    initial begin
        test_reset();
        test_basic_add();
        test_carry_chain();
        test_start_while_busy();
        test_reset_mid_op();
`ifdef SUMADOR_SERIE_OVF_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
